// File: rtl/cpu_pkg.sv
// Shared definitions for the sequential Hack-style CPU: widths, IR field
// positions, FSM state encoding and the wrapping pc increment.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;

    // Instruction register field positions
    localparam int IR_CI   = 15;  // 1 = C-instruction, 0 = A-instruction
    localparam int IR_A    = 12;  // a: ALU y operand is M instead of A
    localparam int IR_C_HI = 11;  // c[5:0] = zx,nx,zy,ny,f,no
    localparam int IR_C_LO = 6;
    localparam int IR_D_HI = 5;   // d[2:0] = A,D,M destinations
    localparam int IR_D_LO = 3;
    localparam int IR_D_A  = 5;
    localparam int IR_D_D  = 4;
    localparam int IR_D_M  = 3;
    localparam int IR_J_HI = 2;   // j[2:0] = lt,eq,gt
    localparam int IR_J_LO = 0;
    localparam int IR_J_NG = 2;
    localparam int IR_J_ZR = 1;
    localparam int IR_J_PS = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM_WR = 3'd4
    } state_t;

    // pc + 1, wrapping 15'h7FFF -> 15'h0000 through truncation
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        return p + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit Hack ALU: optional zero/negate of each operand, add or and,
// optional negate of the result, plus zero and negative flags.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_zero;
    logic [15:0] x_neg;
    logic [15:0] y_zero;
    logic [15:0] y_neg;
    logic [15:0] f_res;

    // Operand conditioning, function select and flag generation
    always_comb begin
        x_zero = zx ? 16'h0000 : x;
        x_neg  = nx ? ~x_zero : x_zero;
        y_zero = zy ? 16'h0000 : y;
        y_neg  = ny ? ~y_zero : y_zero;
        f_res  = f ? (x_neg + y_neg) : (x_neg & y_neg);
        out    = no ? ~f_res : f_res;
        zr     = (out == 16'h0000);
        ng     = out[15];
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle Hack-style CPU with separate req/ack instruction and data
// buses. Instructions go FETCH -> DECODE -> [MEM_RD] -> EXEC -> [MEM_WR].
module cpu_seq
    import cpu_pkg::*;
#(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic [15:0] instr_rdata,
    input  logic        instr_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [14:0] pc
);

    state_t              state_reg;
    state_t              state_next;

    logic [WORD_W-1:0]   a_reg;
    logic [WORD_W-1:0]   d_reg;
    logic [WORD_W-1:0]   ir_reg;
    logic [WORD_W-1:0]   m_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [WORD_W-1:0]   wr_data_reg;
    logic [ADDR_W-1:0]   pc_defer_reg;

    logic [WORD_W-1:0]   alu_y;
    logic [WORD_W-1:0]   alu_out;
    logic                alu_zr;
    logic                alu_ng;
    logic [5:0]          ctl;
    logic                jump;
    logic [ADDR_W-1:0]   pc_plus;
    logic [ADDR_W-1:0]   pc_exec;
    logic                instr_done;
    logic                mem_done;

    assign ctl     = ir_reg[IR_C_HI:IR_C_LO];
    assign alu_y   = ir_reg[IR_A] ? m_reg : a_reg;
    assign pc_plus = pc_inc(pc_reg);

    alu u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (ctl[5]),
        .nx  (ctl[4]),
        .zy  (ctl[3]),
        .ny  (ctl[2]),
        .f   (ctl[1]),
        .no  (ctl[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Jump decision and next pc as seen from EXEC (target is pre-EXEC A)
    always_comb begin
        jump    = (ir_reg[IR_J_NG] & alu_ng)
                | (ir_reg[IR_J_ZR] & alu_zr)
                | (ir_reg[IR_J_PS] & ~alu_zr & ~alu_ng);
        pc_exec = jump ? a_reg[ADDR_W-1:0] : pc_plus;
    end

    // Transfer completion: only counts while the matching request is up
    always_comb begin
        instr_done = instr_req & instr_ack;
        mem_done   = mem_req & mem_ack;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  if (instr_done) state_next = ST_DECODE;
            ST_DECODE: begin
                if (!ir_reg[IR_CI])    state_next = ST_FETCH;
                else if (ir_reg[IR_A]) state_next = ST_MEM_RD;
                else                   state_next = ST_EXEC;
            end
            ST_MEM_RD: if (mem_done) state_next = ST_EXEC;
            ST_EXEC:   state_next = ir_reg[IR_D_M] ? ST_MEM_WR : ST_FETCH;
            ST_MEM_WR: if (mem_done) state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    // FSM outputs; instr_req is gated by reset so nothing is requested while held
    always_comb begin
        instr_req  = (state_reg == ST_FETCH) & ~reset;
        instr_addr = pc_reg;
        pc         = pc_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = a_reg[ADDR_W-1:0];
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr_reg;
                mem_wdata = wr_data_reg;
            end
            default: ;
        endcase
    end

    // Datapath registers, updated according to the current state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg        <= '0;
            d_reg        <= '0;
            ir_reg       <= '0;
            m_reg        <= '0;
            pc_reg       <= RESET_PC;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            pc_defer_reg <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (instr_done) ir_reg <= instr_rdata;
                end
                ST_DECODE: begin
                    if (!ir_reg[IR_CI]) begin
                        a_reg  <= {1'b0, ir_reg[ADDR_W-1:0]};
                        pc_reg <= pc_plus;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_done) m_reg <= mem_rdata;
                end
                ST_EXEC: begin
                    if (ir_reg[IR_D_D]) d_reg <= alu_out;
                    if (ir_reg[IR_D_A]) a_reg <= alu_out;
                    if (ir_reg[IR_D_M]) begin
                        // Capture write address/data from pre-EXEC A and hold the pc
                        wr_addr_reg  <= a_reg[ADDR_W-1:0];
                        wr_data_reg  <= alu_out;
                        pc_defer_reg <= pc_exec;
                    end else begin
                        pc_reg <= pc_exec;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_done) pc_reg <= pc_defer_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: the bench plays instruction and data
// memory, and an instruction-level reference model predicts each step.
module tb_cpu_seq;

    localparam logic [14:0] RST_PC = 15'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic [15:0] instr_rdata;
    logic        instr_ack;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [14:0] pc;

    cpu_seq #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .instr_ack   (instr_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [0:32767];
    logic [15:0] dmem [0:32767];

    // Reference model architectural state
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [14:0] m_pc;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hack ALU as defined by its six control bits
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] r;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? 16'(xx + yy) : (xx & yy);
        if (c[0]) r = ~r;
        return r;
    endfunction

    // Apply reset mid-cycle, check reset state, release on a falling edge
    task automatic do_reset();
        @(negedge clk);
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst.instr_req", 32'(instr_req), 32'd0);
        chk("rst.mem_req",   32'(mem_req),   32'd0);
        chk("rst.mem_we",    32'(mem_we),    32'd0);
        chk("rst.pc",        32'(pc),        32'(RST_PC));
        chk("rst.a",         32'(dut.a_reg),  32'd0);
        chk("rst.d",         32'(dut.d_reg),  32'd0);
        chk("rst.ir",        32'(dut.ir_reg), 32'd0);
        chk("rst.m",         32'(dut.m_reg),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.first_req", 32'(instr_req), 32'd1);
        m_a  = 16'h0000;
        m_d  = 16'h0000;
        m_pc = RST_PC;
    endtask

    // Run one instruction with iw fetch wait cycles and mw wait cycles per
    // data transfer; compare bus activity and results with the model.
    task automatic exec_one(input int iw, input int mw, input string tag);
        logic [15:0] ins;
        logic [15:0] y;
        logic [15:0] res;
        logic [15:0] new_a;
        logic [15:0] new_d;
        logic [14:0] new_pc;
        logic [14:0] exp_wr_addr;
        logic [14:0] exp_rd_addr;
        logic [15:0] exp_wr_data;
        logic [14:0] first_addr;
        logic [14:0] rd_addr_o;
        logic [14:0] wr_addr_o;
        logic [15:0] wr_data_o;
        logic [14:0] x_addr;
        logic [15:0] x_wdata;
        logic        x_we;
        bit          jmp;
        bit          fetched;
        bit          done;
        bit          in_xfer;
        bit          proto_ok;
        int          exp_rd_n;
        int          exp_wr_n;
        int          lat;
        int          cyc;
        int          w;
        int          rd_n;
        int          wr_n;
        int          mem_cyc;

        ins         = imem[m_pc];
        exp_rd_n    = 0;
        exp_wr_n    = 0;
        exp_rd_addr = m_a[14:0];
        exp_wr_addr = m_a[14:0];
        exp_wr_data = 16'h0000;
        if (!ins[15]) begin
            new_a  = {1'b0, ins[14:0]};
            new_d  = m_d;
            new_pc = m_pc + 15'd1;
            lat    = 2 + iw;
        end else begin
            y      = ins[12] ? dmem[m_a[14:0]] : m_a;
            res    = hack_alu(m_d, y, ins[11:6]);
            jmp    = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000)
                     || (ins[0] && $signed(res) > 0);
            new_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
            new_a  = ins[5] ? res : m_a;
            new_d  = ins[4] ? res : m_d;
            exp_rd_n    = ins[12] ? 1 : 0;
            exp_wr_n    = ins[3] ? 1 : 0;
            exp_wr_data = res;
            lat = 3 + iw + (ins[12] ? 1 + mw : 0) + (ins[3] ? 1 + mw : 0);
        end

        first_addr = instr_addr;
        cyc = 0; w = 0; rd_n = 0; wr_n = 0; mem_cyc = 0;
        fetched = 0; done = 0; in_xfer = 0; proto_ok = 1;
        rd_addr_o = '0; wr_addr_o = '0; wr_data_o = '0;
        x_addr = '0; x_wdata = '0; x_we = 1'b0;
        while (!done) begin
            if (instr_req === 1'b1 && mem_req === 1'b1) proto_ok = 0;
            if (mem_req !== 1'b1 && (mem_we !== 1'b0 || mem_wdata !== 16'h0000)) proto_ok = 0;
            if (cyc > 0 && fetched && instr_req === 1'b1) begin
                done      = 1;
                instr_ack = 1'b0;
                mem_ack   = 1'b0;
            end else begin
                if (instr_req === 1'b1) begin
                    if (!in_xfer) begin
                        in_xfer = 1;
                        x_addr  = instr_addr;
                    end else if (instr_addr !== x_addr) proto_ok = 0;
                    if (w >= iw) begin
                        instr_ack   = 1'b1;
                        instr_rdata = imem[instr_addr];
                        fetched = 1; in_xfer = 0; w = 0;
                    end else begin
                        instr_ack   = 1'b0;
                        instr_rdata = 16'($urandom);
                        w++;
                    end
                    mem_ack   = 1'($urandom);
                    mem_rdata = 16'($urandom);
                end else if (mem_req === 1'b1) begin
                    mem_cyc++;
                    if (!in_xfer) begin
                        in_xfer = 1;
                        x_addr = mem_addr; x_we = mem_we; x_wdata = mem_wdata;
                    end else if (mem_addr !== x_addr || mem_we !== x_we || mem_wdata !== x_wdata)
                        proto_ok = 0;
                    if (w >= mw) begin
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            wr_n++;
                            wr_addr_o = mem_addr;
                            wr_data_o = mem_wdata;
                            dmem[mem_addr] = mem_wdata;
                            mem_rdata = 16'($urandom);
                        end else begin
                            rd_n++;
                            rd_addr_o = mem_addr;
                            mem_rdata = dmem[mem_addr];
                        end
                        in_xfer = 0; w = 0;
                    end else begin
                        mem_ack   = 1'b0;
                        mem_rdata = 16'($urandom);
                        w++;
                    end
                    instr_ack   = 1'($urandom);
                    instr_rdata = 16'($urandom);
                end else begin
                    // Stray acks while nothing is requested must be ignored
                    instr_ack   = 1'($urandom);
                    instr_rdata = 16'($urandom);
                    mem_ack     = 1'($urandom);
                    mem_rdata   = 16'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (cyc > 60) begin
                    chk({tag, ".timeout"}, 32'(cyc), 32'(lat));
                    done      = 1;
                    instr_ack = 1'b0;
                    mem_ack   = 1'b0;
                end
            end
        end

        $display("%s: pc=%h ir=%h cycles=%0d reads=%0d writes=%0d next=%h",
                 tag, first_addr, ins, cyc, rd_n, wr_n, instr_addr);
        chk({tag, ".fetch_addr"}, 32'(first_addr), 32'(m_pc));
        chk({tag, ".latency"},    32'(cyc),        32'(lat));
        chk({tag, ".next_pc"},    32'(instr_addr), 32'(new_pc));
        chk({tag, ".reads"},      32'(rd_n),       32'(exp_rd_n));
        chk({tag, ".writes"},     32'(wr_n),       32'(exp_wr_n));
        chk({tag, ".mem_cycles"}, 32'(mem_cyc),    32'((exp_rd_n + exp_wr_n) * (1 + mw)));
        if (exp_rd_n == 1 && rd_n == 1) chk({tag, ".rd_addr"}, 32'(rd_addr_o), 32'(exp_rd_addr));
        if (exp_wr_n == 1 && wr_n == 1) begin
            chk({tag, ".wr_addr"}, 32'(wr_addr_o), 32'(exp_wr_addr));
            chk({tag, ".wr_data"}, 32'(wr_data_o), 32'(exp_wr_data));
        end
        chk({tag, ".a"},        32'(dut.a_reg), 32'(new_a));
        chk({tag, ".d"},        32'(dut.d_reg), 32'(new_d));
        chk({tag, ".protocol"}, 32'(proto_ok),  32'd1);
        m_a  = new_a;
        m_d  = new_d;
        m_pc = new_pc;
    endtask

    initial begin
        bit found;
        reset       = 1'b1;
        instr_ack   = 1'b0;
        mem_ack     = 1'b0;
        instr_rdata = 16'h0000;
        mem_rdata   = 16'h0000;
        for (int i = 0; i < 32768; i++) begin
            imem[i] = 16'($urandom);
            dmem[i] = 16'($urandom);
        end

        // Directed program
        imem[0]  = 16'h0005;  // @5
        imem[1]  = 16'hEC10;  // D=A
        imem[2]  = 16'h0007;  // @7
        imem[3]  = 16'hEFC8;  // M=1
        imem[4]  = 16'h0003;  // @3
        imem[5]  = 16'hFC10;  // D=M
        imem[6]  = 16'h000A;  // @10
        imem[7]  = 16'hEA87;  // 0;JMP
        imem[10] = 16'hEA90;  // D=0
        imem[11] = 16'hE301;  // D;JGT (not taken)
        imem[12] = 16'h7FFF;  // @32767
        imem[13] = 16'hEA87;  // 0;JMP
        imem[32767] = 16'h0011; // @17, pc wraps to 0
        dmem[3]  = 16'h1234;

        do_reset();
        exec_one(0, 0, "d_at5");
        exec_one(0, 0, "d_DeqA");
        exec_one(0, 0, "d_at7");
        exec_one(0, 0, "d_Meq1");
        exec_one(0, 0, "d_at3");
        exec_one(0, 3, "d_DeqM");
        exec_one(0, 0, "d_at10");
        exec_one(0, 0, "d_jmp");
        exec_one(0, 0, "d_Deq0");
        exec_one(0, 0, "d_jgt");
        exec_one(0, 0, "d_at7fff");
        exec_one(2, 0, "d_jmp7fff");
        exec_one(1, 0, "d_wrap");

        // Reset during a write transfer with ack present in the same cycle
        do_reset();
        imem[0] = 16'h0007;
        imem[1] = 16'hEFC8;
        exec_one(0, 0, "r_at7");
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                found = 1;
            end else begin
                instr_ack   = instr_req;
                instr_rdata = imem[instr_addr];
                mem_ack     = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("r.reached_write", 32'(found), 32'd1);
        instr_ack = 1'b0;
        mem_ack   = 1'b1;
        #1 reset  = 1'b1;
        #1;
        chk("r.mem_req_drop", 32'(mem_req),   32'd0);
        chk("r.pc",           32'(pc),        32'(RST_PC));
        chk("r.a",            32'(dut.a_reg), 32'd0);
        chk("r.d",            32'(dut.d_reg), 32'd0);
        @(posedge clk);
        #1;
        chk("r.pc_held",      32'(pc),        32'(RST_PC));
        chk("r.a_held",       32'(dut.a_reg), 32'd0);
        mem_ack = 1'b0;

        // Random program with random wait states
        for (int i = 0; i < 32768; i++) imem[i] = 16'($urandom);
        do_reset();
        for (int k = 0; k < 150; k++) begin
            exec_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter: RESET_PC, default 15'h0000, pc value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr_req  output  1  instruction fetch request.
REQ-005 instr_addr  output  15  fetch address; equals pc.
REQ-006 instr_rdata  input  16  fetched instruction word.
REQ-007 instr_ack  input  1  fetch complete; instr_rdata valid.
REQ-008 mem_req  output  1  data memory request.
REQ-009 mem_we  output  1  1 = write, 0 = read.
REQ-010 mem_addr  output  15  data address.
REQ-011 mem_wdata  output  16  write data.
REQ-012 mem_rdata  input  16  read data.
REQ-013 mem_ack  input  1  data transfer complete.
REQ-014 pc  output  15  address of the current or next instruction.

Function
REQ-015 The block SHALL hold registers A (16b), D (16b), IR (16b), M (16b), pc (15b), plus an FSM with states FETCH, DECODE, MEM_RD, EXEC and MEM_WR.
REQ-016 Handshake: a transfer SHALL complete on the rising edge where req=1 and ack=1; req, addr, we and wdata SHALL stay stable from req assertion until completion; ack with req=0 SHALL be ignored.
REQ-017 FETCH: the block SHALL assert instr_req with instr_addr=pc; on completion it SHALL set IR<=instr_rdata and go to DECODE.
REQ-018 DECODE, IR[15]=0 (A-instruction): the block SHALL set A<={1'b0,IR[14:0]} and pc<=pc+1, then go to FETCH.
REQ-019 DECODE, IR[15]=1 (C-instruction): the block SHALL go to MEM_RD if IR[12]=1, else to EXEC; IR[14:13] SHALL be ignored.
REQ-020 MEM_RD: the block SHALL drive mem_req=1, mem_we=0, mem_addr=A[14:0]; on completion it SHALL set M<=mem_rdata and go to EXEC.
REQ-021 EXEC: the ALU SHALL receive x=D, y=(IR[12] ? M : A), and zx,nx,zy,ny,f,no=IR[11:6]; its out, zr and ng SHALL be used in the same cycle.
REQ-022 EXEC writes: IR[4] SHALL load D<=out, and IR[5] SHALL load A<=out.
REQ-023 If IR[3]=1, EXEC SHALL also latch write address = A[14:0] (pre-EXEC A) and write data = out.
REQ-024 Jump: jump SHALL be (IR[2]&ng)|(IR[1]&zr)|(IR[0]&~zr&~ng); the target SHALL be pre-EXEC A[14:0]; otherwise the next pc SHALL be pc+1.
REQ-025 EXEC exit: if IR[3]=1 the block SHALL go to MEM_WR and defer the pc update, else it SHALL update pc and go to FETCH.
REQ-026 MEM_WR: the block SHALL drive mem_req=1, mem_we=1, mem_addr/mem_wdata from the EXEC latches; on completion it SHALL apply the deferred pc update and go to FETCH.
REQ-027 pc+1 SHALL wrap from 15'h7FFF to 15'h0000.
REQ-028 Zero-wait latency: A-instruction 2 cycles; C-instruction 3 cycles, +1 if IR[12]=1, +1 if IR[3]=1; each ack wait cycle SHALL add exactly 1 cycle.
REQ-029 instr_req and mem_req SHALL never be asserted simultaneously.
REQ-030 mem_we and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-031 While reset=1, asynchronously: state=FETCH, pc=RESET_PC, A=D=IR=M=0, instr_req=mem_req=mem_we=0.
REQ-032 Reset during any transfer SHALL abandon it; no register update SHALL result from a concurrent ack.
REQ-033 The first instr_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the FSM state enum, the IR field positions (a, c[5:0], d[2:0], j[2:0]) and the word widths.
REQ-035 cpu_seq SHALL instantiate the existing 16-bit alu as its one sub-module; all other logic SHALL be local.

Verification
REQ-036 Reset, then fetch 16'h0005 with zero-wait ack -> A=16'h0005, pc=1, instr_req re-asserts 2 cycles after the first.
REQ-037 Sequence @5 (16'h0005), D=A (16'hEC10) -> D=16'h0005, no mem_req, pc=2.
REQ-038 @7 (16'h0007), M=1 (16'hEFC8) -> exactly one write: mem_addr=7, mem_wdata=16'h0001, mem_we=1; pc=2 after it.
REQ-039 @3, D=M (16'hFC10), mem_ack delayed 3 cycles, mem_rdata=16'h1234 -> mem_req held 4 cycles, D=16'h1234.
REQ-040 @10 (16'h000A), 0;JMP (16'hEA87) -> next instr_addr=10; with D=0, D;JGT (16'hE301) -> no jump, pc+1.
REQ-041 Reset asserted mid-MEM_WR with mem_ack=1 the same cycle -> mem_req drops immediately, pc=RESET_PC, A/D=0.
